// File: rtl/rr_arb5_mux_ctrl.sv
// Five-way round-robin arbiter with hold limit, driving the select lines of a
// 5:1 mux and returning the granted requester's data bit one cycle later.
module rr_arb5_mux_ctrl #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] req,
    input  logic [4:0] din,
    output logic [4:0] gnt,
    output logic       s2,
    output logic       s1,
    output logic       s0,
    output logic       dout,
    output logic       dout_valid
);

    localparam int unsigned N  = 5;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = IW + 1;
    localparam int unsigned HW = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [N-1:0]    gnt_d;
    logic            dout_d;
    logic            valid_d;
    logic            load;
    logic [IW-1:0]   win_idx;
    logic            win_found;
    logic [CW-1:0]   cand;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
        return (i == IW'(N - 1)) ? '0 : IW'(i + IW'(1));
    endfunction

    // First requester found walking from ptr upward, modulo 5
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + CW'(k);
            if (cand >= CW'(N)) cand = cand - CW'(N);
            if (!win_found && req[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

    // Next-state, grant and data path
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        load    = 1'b0;
        gnt_d   = '0;
        dout_d  = (state_q == GRANT) ? din[idx_q] : 1'b0;
        valid_d = (state_q == GRANT);

        case (state_q)
            IDLE: begin
                if (win_found) load = 1'b1;
            end
            GRANT: begin
                if (req[idx_q] && (hold_q < HW'(MAX_HOLD))) begin
                    hold_d = hold_q + HW'(1);
                end else if (win_found) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                    idx_d   = '0;
                    hold_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A load also covers re-granting the same index after hold expiry
        if (load) begin
            state_d = GRANT;
            idx_d   = win_idx;
            ptr_d   = next_ptr(win_idx);
            hold_d  = HW'(1);
        end

        if (state_d == GRANT) gnt_d[idx_d] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            ptr_q      <= '0;
            hold_q     <= '0;
            gnt        <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            gnt        <= gnt_d;
            dout       <= dout_d;
            dout_valid <= valid_d;
        end
    end

    // Granted index in binary is exactly the mux select (4 -> 100)
    assign s2 = idx_q[2];
    assign s1 = idx_q[1];
    assign s0 = idx_q[0];

endmodule

// File: tb/tb_rr_arb5_mux_ctrl.sv
// Self-checking bench for rr_arb5_mux_ctrl: directed scenarios plus random
// request traffic compared against an integer-level arbitration model.
module tb_rr_arb5_mux_ctrl;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [4:0] req;
    logic [4:0] din;
    logic [4:0] gnt;
    logic       s2, s1, s0;
    logic       dout;
    logic       dout_valid;

    int checks   = 0;
    int failures = 0;

    // Reference model: granted index (-1 when idle), pointer, hold count
    int m_g     = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_dout  = 1'b0;
    bit m_valid = 1'b0;

    rr_arb5_mux_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .din        (din),
        .gnt        (gnt),
        .s2         (s2),
        .s1         (s1),
        .s0         (s0),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rr_pick(input logic [4:0] r, input int from);
        for (int k = 0; k < 5; k++)
            if (r[(from + k) % 5]) return (from + k) % 5;
        return -1;
    endfunction

    task automatic model_reset();
        m_g = -1; m_ptr = 0; m_hold = 0; m_dout = 1'b0; m_valid = 1'b0;
    endtask

    task automatic model_edge(input logic [4:0] r, input logic [4:0] d);
        int w;
        m_dout  = (m_g >= 0) ? d[m_g] : 1'b0;
        m_valid = (m_g >= 0);
        if (m_g >= 0 && r[m_g] && m_hold < MAX_HOLD) begin
            m_hold++;
        end else begin
            w = rr_pick(r, m_ptr);
            if (w < 0) begin
                m_g = -1; m_hold = 0;
            end else begin
                m_g = w; m_hold = 1; m_ptr = (w + 1) % 5;
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [4:0] eg;
        logic [2:0] es;
        eg = '0;
        es = '0;
        if (m_g >= 0) begin
            eg[m_g] = 1'b1;
            es = 3'(m_g);
        end
        check_val({tag, ".gnt"},   8'(gnt), 8'(eg));
        check_val({tag, ".sel"},   8'({s2, s1, s0}), 8'(es));
        check_val({tag, ".dout"},  8'(dout), 8'(m_dout));
        check_val({tag, ".valid"}, 8'(dout_valid), 8'(m_valid));
        check_val({tag, ".onehot"}, 8'($onehot0(gnt)), 8'd1);
    endtask

    // Drive inputs away from the edge, advance one clock, then compare
    task automatic step(input logic [4:0] r, input logic [4:0] d, input string tag);
        req = r;
        din = d;
        @(posedge clk);
        model_edge(r, d);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all(tag);
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        logic [4:0] r;
        logic [4:0] prev;
        int mode;
        rst_n = 1'b0;
        req   = '0;
        din   = '0;
        #1;
        model_reset();
        check_all("por");
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Single request to index 2, data follows one cycle later
        step(5'b00100, 5'b00100, "s1a");
        check_val("s1.gnt", 8'(gnt), 8'b00100);
        check_val("s1.sel", 8'({s2, s1, s0}), 8'b010);
        step(5'b00100, 5'b00100, "s1b");
        check_val("s1.dout", 8'({dout, dout_valid}), 8'b11);

        // All requesting: each index held MAX_HOLD cycles in turn
        do_reset("rst2");
        for (int k = 0; k < 24; k++) begin
            step(5'b11111, 5'(k * 7), "s2");
            check_val("s2.seq", 8'(gnt), 8'(1 << ((k / MAX_HOLD) % 5)));
        end

        // Lone requester 4 keeps the grant across hold expiry
        do_reset("rst3");
        for (int k = 0; k < 10; k++) begin
            step(5'b10000, 5'b10000, "s3");
            check_val("s3.gnt", 8'(gnt), 8'b10000);
        end

        // Requester 0 drops; switch straight to 1
        do_reset("rst4");
        step(5'b00011, 5'b00001, "s4a");
        check_val("s4.g0", 8'(gnt), 8'b00001);
        step(5'b00011, 5'b00001, "s4b");
        step(5'b00010, 5'b00010, "s4c");
        check_val("s4.g1", 8'(gnt), 8'b00010);

        // One-cycle pulse on index 3
        do_reset("rst5");
        step(5'b01000, 5'b01000, "s5a");
        check_val("s5.gnt", 8'(gnt), 8'b01000);
        step(5'b00000, 5'b00000, "s5b");
        check_val("s5.idle", 8'({gnt, s2, s1, s0}), 8'd0);

        // Reset in the middle of a grant to index 3
        step(5'b01000, 5'b01000, "s6a");
        step(5'b01000, 5'b01000, "s6b");
        do_reset("s6.rst");
        check_val("s6.zero", 8'({gnt, dout_valid}), 8'd0);
        step(5'b11111, 5'b11111, "s6c");
        check_val("s6.first", 8'(gnt), 8'b00001);

        // Random traffic
        prev = '0;
        for (int k = 0; k < 400; k++) begin
            mode = $urandom_range(0, 4);
            case (mode)
                0, 1:    r = prev;
                2:       r = 5'($urandom);
                3:       r = '0;
                default: begin r = '0; r[$urandom_range(0, 4)] = 1'b1; end
            endcase
            prev = r;
            step(r, 5'($urandom), "rnd");
            if (k == 200) do_reset("rnd.rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arb5_mux_ctrl.md
RR_ARB5_MUX_CTRL -- requirements
Module: rr_arb5_mux_ctrl

Interface
REQ-001 Parameter MAX_HOLD, default 4, maximum consecutive cycles one requester keeps the grant while others wait; legal range 1..15.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  5  request from requesters 0..4; level-sensitive.
REQ-005 din  input  5  data bit per requester; din[i] is requester i's data.
REQ-006 gnt  output  5  one-hot grant, or all-zero when idle; registered.
REQ-007 s2, s1, s0  output  1 each  registered select for the team's 5:1 mux (four-way stage on s1/s0, then two-way stage on s2).
REQ-008 dout  output  1  registered data of the granted requester.
REQ-009 dout_valid  output  1  high when dout carries granted data.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (gnt=0) and GRANT (exactly one gnt bit high).
REQ-011 Arbitration SHALL be round-robin: search order starts at ptr and proceeds ptr, ptr+1, ... modulo 5; the first requesting index wins.
REQ-012 ptr SHALL be updated to (winner+1) mod 5 on every edge where a new winner is loaded, including a re-grant to the same index.
REQ-013 IDLE -> GRANT on the edge where req != 0; gnt visible one cycle after req is first sampled high.
REQ-014 In GRANT with granted index g, hold_cnt SHALL count cycles of the current grant, starting at 1 when the grant is loaded.
REQ-015 In GRANT, if req[g]=1 and hold_cnt<MAX_HOLD, the grant SHALL be held and hold_cnt incremented.
REQ-016 In GRANT, if req[g]=0, or hold_cnt=MAX_HOLD, the block SHALL re-arbitrate on that edge.
REQ-017 During re-arbitration with other requests pending, the grant SHALL switch directly to the new winner with no idle cycle.
REQ-018 During re-arbitration with no requests, the FSM SHALL return to IDLE and gnt=0.
REQ-019 During re-arbitration when only g still requests (hold expiry), g SHALL be re-granted and hold_cnt reset to 1.
REQ-020 Select encoding SHALL track gnt in the same cycle: index 0..3 -> s2=0, {s1,s0}=index in binary; index 4 -> s2=1, {s1,s0}=00; IDLE -> 000.
REQ-021 dout SHALL equal din[g] registered one cycle after gnt[g] is high; dout_valid SHALL equal gnt!=0 delayed one cycle.
REQ-022 When dout_valid=0, dout SHALL be 0.
REQ-023 The pipeline from a req edge to dout_valid SHALL be two cycles, with one-cycle bubbles only after IDLE.
REQ-024 gnt SHALL never have more than one bit set; the select outputs SHALL never encode an index above 4.
REQ-025 A requester that drops req SHALL lose the grant on the next edge regardless of hold_cnt.

Reset
REQ-026 While rst_n=0, the block SHALL immediately force: state IDLE; gnt=00000; s2,s1,s0=000; dout=0; dout_valid=0; ptr=0; hold_cnt=0.
REQ-027 Reset asserted mid-grant SHALL abort the grant with no further dout_valid.
REQ-028 After rst_n rises, arbitration SHALL resume on the first rising clk edge with ptr=0.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Reset, then req=00100, din=00100 -> next cycle gnt=00100 and s2s1s0=010; the following cycle dout=1 and dout_valid=1.
- req=11111 held constantly, MAX_HOLD=4 -> grants 0,1,2,3,4,0, each high 4 cycles with no gaps; s2s1s0 = 000, 001, 010, 011, 100.
- Only req[4] held for 10 cycles -> gnt=10000 continuously; hold_cnt wraps 4 -> 1; no drop to IDLE.
- gnt=00001 with req=00011, req[0] drops at cycle 2 -> next edge gnt=00010 with no idle cycle.
- Single pulse req=01000 for one cycle -> gnt=01000 for one cycle, then IDLE with gnt=00000 and s2s1s0=000.
- rst_n pulsed low during a grant to index 3 -> gnt, select and dout_valid go to 0 asynchronously; after release with req=11111, the first grant is index 0.
